// File: rtl/sseg_arb_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Each digit is {en, hex[3:0], dp}; a frame is eight digits, digit 0 in the LSBs.
package sseg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        BLANK = 2'd2
    } arb_state_e;

    localparam int DIGIT_W    = 6;
    localparam int NUM_DIGITS = 8;
    localparam int FRAME_W    = DIGIT_W * NUM_DIGITS;

    localparam int EN_BIT  = 5;
    localparam int HEX_MSB = 4;
    localparam int HEX_LSB = 1;
    localparam int DP_BIT  = 0;

    // Assemble one digit field from its enable, hex nibble and decimal point.
    function automatic logic [DIGIT_W-1:0] make_digit(
        input logic                     en,
        input logic [HEX_MSB-HEX_LSB:0] hex,
        input logic                     dp
    );
        logic [DIGIT_W-1:0] d;
        d                   = '0;
        d[EN_BIT]           = en;
        d[HEX_MSB:HEX_LSB]  = hex;
        d[DP_BIT]           = dp;
        return d;
    endfunction

endpackage

// File: rtl/sseg_rr_picker.sv
// Rotating-priority search: returns the first asserted request found when
// scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
module sseg_rr_picker #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic                     found,
    output logic [$clog2(N_REQ)-1:0] index
);

    localparam int IDX_W = $clog2(N_REQ);

    // Scan from the farthest offset down so the nearest hit to rr_ptr wins.
    always_comb begin
        int idx;
        found = 1'b0;
        index = '0;
        idx   = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx   = (int'(rr_ptr) + i) % N_REQ;
            found = req[idx] ? 1'b1 : found;
            index = req[idx] ? IDX_W'(idx) : index;
        end
    end

endmodule

// File: rtl/sseg_display_arbiter.sv
// Round-robin arbiter sharing one 8-digit seven-segment driver among N_REQ
// requesters, with a minimum hold time and an all-off gap between owners.
// Optional build macro SSEG_ARB_OWNER_TAG_EN: while a requester owns the
// display, digit 7 is replaced by the owner number (enabled, no dp).
module sseg_display_arbiter
    import sseg_arb_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int HOLD_CYCLES  = 100_000_000,
    parameter int BLANK_CYCLES = 1_000_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*FRAME_W-1:0]   frame_in,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   owner_id,
    output logic [FRAME_W-1:0]         frame_out,
    output logic                       busy
);

    localparam int IDX_W   = $clog2(N_REQ);
    localparam int MAX_CNT = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_REQ - 1);

    arb_state_e           state_q,    state_d;
    logic [N_REQ-1:0]     grant_q,    grant_d;
    logic [IDX_W-1:0]     owner_id_q, owner_id_d;
    logic [FRAME_W-1:0]   frame_q,    frame_d;
    logic                 busy_q,     busy_d;
    logic [IDX_W-1:0]     rr_ptr_q,   rr_ptr_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;

    logic                 pick_found_s;
    logic [IDX_W-1:0]     pick_idx_s;
    logic [FRAME_W-1:0]   owner_frame_s;
    logic                 owner_req_s;
    logic                 others_req_s;

    sseg_rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .found  (pick_found_s),
        .index  (pick_idx_s)
    );

    // Select the owner's frame, optionally stamping the owner number on digit 7.
    always_comb begin
        owner_frame_s = frame_in[int'(owner_id_q)*FRAME_W +: FRAME_W];
`ifdef SSEG_ARB_OWNER_TAG_EN
        owner_frame_s[FRAME_W-1 -: DIGIT_W] = make_digit(1'b1, 4'(owner_id_q), 1'b0);
`endif
    end

    // Owner still wants the display / anyone else is waiting for it.
    always_comb begin
        owner_req_s  = req[owner_id_q];
        others_req_s = |(req & ~grant_q);
    end

    // Arbitration next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_id_d = owner_id_q;
        frame_d    = frame_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                frame_d = '0;
                if (pick_found_s) begin
                    state_d    = OWN;
                    grant_d    = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
                    owner_id_d = pick_idx_s;
                    cnt_d      = '0;
                end else begin
                    grant_d = '0;
                end
            end
            OWN: begin
                if (!owner_req_s || ((cnt_q == HOLD_LAST) && others_req_s)) begin
                    state_d  = BLANK;
                    grant_d  = '0;
                    frame_d  = '0;
                    rr_ptr_d = (owner_id_q == LAST_IDX) ? '0 : owner_id_q + IDX_W'(1);
                    cnt_d    = '0;
                end else begin
                    frame_d = owner_frame_s;
                    cnt_d   = (cnt_q == HOLD_LAST) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            BLANK: begin
                frame_d = '0;
                grant_d = '0;
                if (cnt_q == BLANK_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                grant_d  = '0;
                frame_d  = '0;
                cnt_d    = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_id_q <= '0;
            frame_q    <= '0;
            busy_q     <= 1'b0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_id_q <= owner_id_d;
            frame_q    <= frame_d;
            busy_q     <= busy_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign grant     = grant_q;
    assign owner_id  = owner_id_q;
    assign frame_out = frame_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sseg_display_arbiter.sv
// Self-checking bench for sseg_display_arbiter (N_REQ=4, HOLD=8, BLANK=2).
// A behavioural model tracks the current owner, its age and the blanking
// countdown, and predicts the outputs after every clock edge.
module tb_sseg_display_arbiter;

    localparam int N  = 4;
    localparam int H  = 8;
    localparam int B  = 2;
    localparam int FW = 48;

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       req;
    logic [N*FW-1:0]    frame_in;
    logic [N-1:0]       grant;
    logic [1:0]         owner_id;
    logic [FW-1:0]      frame_out;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    // model state
    int          m_owner;   // -1 when nobody owns the display
    int          m_age;     // cycles owned so far
    int          m_blank;   // blank cycles still to go
    int          m_ptr;     // first index scanned in the next idle pick
    logic [FW-1:0] m_frame;

    sseg_display_arbiter #(
        .N_REQ        (N),
        .HOLD_CYCLES  (H),
        .BLANK_CYCLES (B)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .frame_in  (frame_in),
        .grant     (grant),
        .owner_id  (owner_id),
        .frame_out (frame_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] exp_slice(input int k);
        logic [FW-1:0] s;
        s = frame_in[k*FW +: FW];
`ifdef SSEG_ARB_OWNER_TAG_EN
        s[47:42] = {1'b1, 4'(k), 1'b0};
`endif
        return s;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_blank = 0;
        m_ptr   = 0;
        m_frame = '0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        if (reset) begin
            model_reset();
        end else if (m_owner >= 0) begin
            logic others;
            others = |(req & ~(4'b0001 << m_owner));
            if (!req[m_owner] || (m_age >= H - 1 && others)) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_blank = B;
                m_frame = '0;
            end else begin
                m_age++;
                m_frame = exp_slice(m_owner);
            end
        end else if (m_blank > 0) begin
            m_blank--;
            m_frame = '0;
        end else begin
            m_frame = '0;
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_age   = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] eg;
        int         ow;
        ow = m_owner;
        eg = (ow >= 0) ? (4'b0001 << ow) : 4'b0000;
        chk("grant", grant, eg);
        chk("busy", busy, (ow >= 0 || m_blank > 0));
        chk("frame_out", frame_out, m_frame);
        chk("grant_onehot", ($countones(grant) <= 1), 1'b1);
        if (ow >= 0) chk("owner_id", owner_id, ow[1:0]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic randomize_frames();
        for (int w = 0; w < N * FW / 32; w++) frame_in[w*32 +: 32] = $urandom;
    endtask

    initial begin
        int waited;
        reset = 1'b1;
        req   = 4'b0000;
        frame_in = '0;
        randomize_frames();
        model_reset();

        // Reset state and quiet idle
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_owner_id", owner_id, 2'd0);
        repeat (20) tick();

        // Single requester 2, frames changing under it
        req = 4'b0100;
        tick();
        chk("req2_grant", grant, 4'b0100);
        chk("req2_owner", owner_id, 2'd2);
        tick();
        randomize_frames();
        tick();
        randomize_frames();
        tick();
        // Requester 0 joins; owner 2 keeps the display until hold expires
        req = 4'b0101;
        repeat (14) tick();

        // Everyone requesting: full rotation
        req = 4'b1111;
        for (int c = 0; c < 60; c++) begin
            if (c % 7 == 0) randomize_frames();
            tick();
        end

        // Drain, then owner 1 drops early with nobody else waiting
        req = 4'b0000;
        repeat (12) tick();
        req = 4'b0010;
        waited = 0;
        while (m_owner != 1 && waited < 10) begin
            tick();
            waited++;
        end
        chk("owner1_granted_in_time", (m_owner == 1), 1'b1);
        tick();
        req = 4'b0000;
        repeat (5) tick();
        req = 4'b0010;
        repeat (2) tick();
        chk("owner1_regrant", grant, 4'b0010);
        repeat (3) tick();

        // Asynchronous reset in the middle of an ownership
        chk("pre_reset_busy", busy, 1'b1);
        @(posedge clk);
        model_step();
        #3;
        reset = 1'b1;
        #1;
        chk("async_grant", grant, 4'b0000);
        chk("async_frame", frame_out, 48'h0);
        chk("async_busy", busy, 1'b0);
        model_reset();
        tick();
        reset = 1'b0;
        req   = 4'b1010;
        tick();
        chk("post_reset_grant", grant, 4'b0010);
        repeat (3) tick();
`ifdef SSEG_ARB_OWNER_TAG_EN
        chk("owner_tag", frame_out[47:42], 6'b100010);
`endif

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 5) == 0) req = 4'($urandom);
            if ($urandom_range(0, 3) == 0) randomize_frames();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
